// File: rtl/sim_uart_pkg.sv
// Constants and types shared by the simulator UART receive path and the command-byte transmit path.
// Holds the status header code, the detector bit positions and the receive FSM encoding.
package sim_uart_pkg;

   localparam logic [1:0] STATUS_HDR = 2'b10;

   localparam int DET_FRONT = 0;
   localparam int DET_LEFT  = 1;
   localparam int DET_RIGHT = 2;
   localparam int DET_BACK  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   function automatic logic is_status_hdr(input logic [1:0] hdr);
      return hdr == STATUS_HDR;
   endfunction

endpackage

// File: rtl/sim_status_receiver_if.sv
// Decoded status bundle from the simulator link receiver to the driving-mode logic.
// The receiver drives it through master; consumers read it through slave.
interface sim_status_receiver_if;

   logic [7:0] rx_byte;
   logic       byte_valid;
   logic       frame_err;
   logic       hdr_err;
   logic       det_front;
   logic       det_left;
   logic       det_right;
   logic       det_back;
   logic       link_ok;
   logic [7:0] err_cnt;

   modport master (
      output rx_byte, byte_valid, frame_err, hdr_err,
      output det_front, det_left, det_right, det_back,
      output link_ok, err_cnt
   );

   modport slave (
      input rx_byte, byte_valid, frame_err, hdr_err,
      input det_front, det_left, det_right, det_back,
      input link_ok, err_cnt
   );

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser: 2-flop synchroniser, oversampling tick divider and bit FSM.
// good_o/ferr_o are single-cycle pulses on the stop-bit mid-sample cycle; data_o holds the shifted byte.
module uart_rx_core
   import sim_uart_pkg::*;
#(
   parameter int TICK_DIV = 651,
   parameter int OVS      = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       good_o,
   output logic       ferr_o
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int OW = (OVS > 1) ? $clog2(OVS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [OW-1:0] OS_MID    = OW'(OVS / 2 - 1);
   localparam logic [OW-1:0] OS_LAST   = OW'(OVS - 1);

   logic            rx_meta_q;
   logic            rx_sync_q;
   logic            rx_prev_q;

   rx_state_e       state_q;
   rx_state_e       state_d;
   logic [TW-1:0]   tick_cnt_q;
   logic [TW-1:0]   tick_cnt_d;
   logic [OW-1:0]   os_cnt_q;
   logic [OW-1:0]   os_cnt_d;
   logic [2:0]      bit_cnt_q;
   logic [2:0]      bit_cnt_d;
   logic [7:0]      shift_q;
   logic [7:0]      shift_d;

   logic            tick;
   logic            fall;
   logic            sample;

   // Synchroniser idles high so reset never looks like a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign fall   = rx_prev_q & ~rx_sync_q;
   assign tick   = (tick_cnt_q == TICK_LAST);
   assign sample = tick && (os_cnt_q == ((state_q == START) ? OS_MID : OS_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (fall) state_d = START;
         START:   if (sample) state_d = rx_sync_q ? IDLE : DATA;
         DATA:    if (sample && (bit_cnt_q == 3'd7)) state_d = STOP;
         STOP:    if (sample) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      good_o = 1'b0;
      ferr_o = 1'b0;
      if ((state_q == STOP) && sample) begin
         good_o = rx_sync_q;
         ferr_o = ~rx_sync_q;
      end
   end

   assign data_o = shift_q;

   // The oversample counter restarts after each sample, so START waits half a bit and later states a full bit.
   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      os_cnt_d   = os_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      if (state_q == IDLE) begin
         os_cnt_d  = '0;
         bit_cnt_d = '0;
         if (fall) begin
            tick_cnt_d = '0;
         end
      end else if (tick) begin
         os_cnt_d = sample ? '0 : os_cnt_q + 1'b1;
         if (sample && (state_q == DATA)) begin
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q <= '0;
         os_cnt_q   <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         os_cnt_q   <= os_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
      end
   end

endmodule

// File: rtl/sim_status_receiver.sv
// Simulator status receiver: UART bytes -> header check, obstacle flags, link-alive timer, error strobes.
// Build option RX_ERR_CNT_EN adds a saturating frame/header error counter; otherwise err_cnt reads 0.
module sim_status_receiver
   import sim_uart_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVS        = 16,
   parameter int TIMEOUT_MS = 500
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx,
   sim_status_receiver_if.master  st
);

   localparam int TICK_DIV    = CLK_HZ / (BAUD * OVS);
   localparam int TIMEOUT_CYC = (CLK_HZ / 1000) * TIMEOUT_MS;
   localparam int LW          = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [LW-1:0] LINK_LAST = LW'(TIMEOUT_CYC - 1);

   logic [7:0]    core_data;
   logic          core_good;
   logic          core_ferr;
   logic          status_ok;
   logic          hdr_bad;
   logic          link_expire;

   logic [7:0]    rx_byte_q;
   logic [7:0]    rx_byte_d;
   logic          byte_valid_q;
   logic          frame_err_q;
   logic          hdr_err_q;
   logic [3:0]    det_q;
   logic [3:0]    det_d;
   logic          link_ok_q;
   logic          link_ok_d;
   logic [LW-1:0] link_cnt_q;
   logic [LW-1:0] link_cnt_d;

   uart_rx_core #(
      .TICK_DIV (TICK_DIV),
      .OVS      (OVS)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .rx_i   (rx),
      .data_o (core_data),
      .good_o (core_good),
      .ferr_o (core_ferr)
   );

   assign status_ok   = core_good && is_status_hdr(core_data[7:6]);
   assign hdr_bad     = core_good && !is_status_hdr(core_data[7:6]);
   assign link_expire = link_ok_q && (link_cnt_q == LINK_LAST);

   // A status frame landing on the expiry cycle takes priority and keeps the link up.
   always_comb begin
      rx_byte_d  = core_good ? core_data : rx_byte_q;
      det_d      = det_q;
      link_ok_d  = link_ok_q;
      link_cnt_d = link_cnt_q;
      if (status_ok) begin
         det_d      = core_data[3:0];
         link_ok_d  = 1'b1;
         link_cnt_d = '0;
      end else if (link_expire) begin
         det_d      = '0;
         link_ok_d  = 1'b0;
         link_cnt_d = '0;
      end else if (link_ok_q) begin
         link_cnt_d = link_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_byte_q    <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         hdr_err_q    <= 1'b0;
         det_q        <= '0;
         link_ok_q    <= 1'b0;
         link_cnt_q   <= '0;
      end else begin
         rx_byte_q    <= rx_byte_d;
         byte_valid_q <= core_good;
         frame_err_q  <= core_ferr;
         hdr_err_q    <= hdr_bad;
         det_q        <= det_d;
         link_ok_q    <= link_ok_d;
         link_cnt_q   <= link_cnt_d;
      end
   end

`ifdef RX_ERR_CNT_EN
   logic [7:0] err_cnt_q;
   logic [7:0] err_cnt_d;

   // Frame and header errors are mutually exclusive, so one increment per cycle is enough.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((core_ferr || hdr_bad) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign st.err_cnt = err_cnt_q;
`else
   assign st.err_cnt = 8'h00;
`endif

   assign st.rx_byte    = rx_byte_q;
   assign st.byte_valid = byte_valid_q;
   assign st.frame_err  = frame_err_q;
   assign st.hdr_err    = hdr_err_q;
   assign st.det_front  = det_q[DET_FRONT];
   assign st.det_left   = det_q[DET_LEFT];
   assign st.det_right  = det_q[DET_RIGHT];
   assign st.det_back   = det_q[DET_BACK];
   assign st.link_ok    = link_ok_q;

endmodule

// File: tb/tb_sim_status_receiver.sv
// Scoreboard bench for sim_status_receiver at scaled-down rates (1 clock per tick, 640-cycle link window).
// Driver serialises bytes and queues expected strobes; a negedge monitor checks strobes and link/detector state.
module tb_sim_status_receiver;

   localparam int BIT = 16;
   localparam int T   = 640;

   typedef struct {
      logic [7:0] data;
      logic [2:0] flags;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   rst_seen = 1'b0;
   exp_t exp_q[$];

   exp_t       e;
   logic [2:0] got_flags;
   logic [7:0] m_byte = '0;
   logic [3:0] m_det = '0;
   bit         m_link = 1'b0;
   int         m_last = 0;
   int         m_err = 0;
   logic [7:0] err_exp;
   int         last_bv_cyc = 0;
   int         last_start = 0;
   int         lat = 0;
   int         v = 0;

   sim_status_receiver_if sif ();

   sim_status_receiver #(
      .CLK_HZ     (16000),
      .BAUD       (1000),
      .OVS        (16),
      .TIMEOUT_MS (40)
   ) dut (
      .clk (clk),
      .rst (rst),
      .rx  (rx),
      .st  (sif)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic drive(input logic val, input int n);
      rx = val;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b, input bit stop_bad, input int gap_bits);
      exp_t x;
      x.data  = b;
      x.flags = stop_bad ? 3'b001 : ((b[7:6] == 2'b10) ? 3'b100 : 3'b110);
      exp_q.push_back(x);
      last_start = cyc;
      drive(1'b0, BIT);
      for (int i = 0; i < 8; i++) drive(b[i], BIT);
      drive(!stop_bad, BIT);
      drive(1'b1, gap_bits * BIT);
   endtask

   // Monitor: expected link state is "a status frame was accepted fewer than T cycles ago".
   always @(negedge clk) begin
      if (rst_seen) begin
         check("reset_outputs",
               {sif.rx_byte, sif.byte_valid, sif.frame_err, sif.hdr_err, sif.det_back,
                sif.det_right, sif.det_left, sif.det_front, sif.link_ok, sif.err_cnt}, 32'd0);
         m_byte = '0;
         m_det  = '0;
         m_link = 1'b0;
         m_err  = 0;
         exp_q.delete();
      end else begin
         got_flags = {sif.byte_valid, sif.hdr_err, sif.frame_err};
         if (sif.byte_valid) last_bv_cyc = cyc;
         if (got_flags != 3'b000) begin
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", {29'd0, got_flags}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("strobes", {29'd0, got_flags}, {29'd0, e.flags});
               if (e.flags == 3'b001) begin
                  m_err++;
               end else begin
                  m_byte = e.data;
                  check("rx_byte_on_strobe", {24'd0, sif.rx_byte}, {24'd0, e.data});
                  if (e.flags == 3'b110) begin
                     m_err++;
                  end else begin
                     m_link = 1'b1;
                     m_last = cyc;
                     m_det  = e.data[3:0];
                  end
               end
            end
         end
         if (m_link && (cyc - m_last >= T)) begin
            m_link = 1'b0;
            m_det  = '0;
         end
`ifdef RX_ERR_CNT_EN
         err_exp = (m_err > 255) ? 8'hFF : 8'(m_err);
`else
         err_exp = 8'h00;
`endif
         check("link_ok", {31'd0, sif.link_ok}, {31'd0, m_link});
         check("det", {28'd0, sif.det_back, sif.det_right, sif.det_left, sif.det_front},
               {28'd0, m_det});
         check("rx_byte", {24'd0, sif.rx_byte}, {24'd0, m_byte});
         check("err_cnt", {24'd0, sif.err_cnt}, {24'd0, err_exp});
      end
   end

   initial begin
      #1_500_000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      bit         sb;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b1, 2 * BIT);

      send(8'h85, 1'b0, 1);
      lat = last_bv_cyc - last_start;
      send(8'h3F, 1'b0, 1);
      send(8'h8F, 1'b1, 1);
      send(8'h80, 1'b0, 1);

      drive(1'b0, 3);
      drive(1'b1, 2 * BIT);
      send(8'h8A, 1'b0, 1);

      // Let the link expire, then land a frame exactly on the expiry cycle.
      send(8'h8F, 1'b0, 0);
      drive(1'b1, T + 2 * BIT);
      send(8'h8F, 1'b0, 0);
      v = last_bv_cyc;
      while (cyc < v + T - lat) begin
         @(posedge clk);
         #1;
      end
      send(8'h85, 1'b0, 2);
      check("expiry_frame_cycle", last_bv_cyc, v + T);

      // Reset in the middle of data bit 4 of 0x8F, with rx returned high first.
      b = 8'h8F;
      drive(1'b0, BIT);
      for (int i = 0; i < 4; i++) drive(b[i], BIT);
      drive(b[4], BIT / 2);
      rx  = 1'b1;
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      drive(1'b1, 2 * BIT);
      send(8'h81, 1'b0, 1);

      for (int k = 0; k < 24; k++) begin
         b  = 8'($urandom);
         if ($urandom_range(0, 1) == 1) b[7:6] = 2'b10;
         sb = ($urandom_range(0, 7) == 0);
         send(b, sb, sb ? 1 + $urandom_range(0, 2) : $urandom_range(0, 3));
      end

      for (int k = 0; k < 300; k++) begin
         b = {1'b0, 7'($urandom)};
         send(b, 1'b0, 0);
      end
      drive(1'b1, BIT);
`ifdef RX_ERR_CNT_EN
      check("err_cnt_saturated", {24'd0, sif.err_cnt}, 32'h0000_00FF);
`else
      check("err_cnt_saturated", {24'd0, sif.err_cnt}, 32'h0000_0000);
`endif
      send(8'h81, 1'b0, 4);
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
